// File: rtl/cpu_arb_pkg.sv
// cpu_arb_pkg: shared state/grant encodings and default widths for the IF/M memory arbiter
package cpu_arb_pkg;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_MEM_LAT = 2;
    localparam int DEF_STARVE_MAX = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D = 1'b1;
endpackage

// File: rtl/arb_lat_counter.sv
// arb_lat_counter: load/decrement counter timing the fixed memory latency, done at zero
module arb_lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);
    logic [W-1:0] cnt;
    // load at issue, then count down toward zero while an access is in flight
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && cnt != '0) cnt <= cnt - 1'b1;
    assign done = (cnt == '0);
endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one single-ported memory between instruction fetch and data access
// Optional ARB_PERF_CNT_EN adds saturating stall/conflict performance counters.
module cpu_mem_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              stall_if,
    output logic              stall_pipe,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]       perf_if_stall,
    output logic [15:0]       perf_conflict
`endif
);
    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [1:0]    state, next_state;
    logic [SW-1:0] starve_cnt;
    logic elig_if, elig_d, starved, gnt_valid, gnt, cnt_done, lat_done, flush_r, if_fin, d_fin;

    assign elig_if = if_req & ~if_ack;
    assign elig_d = d_req & ~d_ack;
    assign starved = (starve_cnt == SW'(STARVE_MAX));
    assign gnt_valid = (state == ST_IDLE) & (elig_if | elig_d);
    assign gnt = (elig_if & (~elig_d | starved)) ? GNT_IF : GNT_D;
    assign lat_done = (state != ST_IDLE) & cnt_done;
    assign if_fin = lat_done & (state == ST_BUSY_IF) & ~flush_r & if_req;
    assign d_fin = lat_done & (state == ST_BUSY_D);

    arb_lat_counter #(.W(LW)) u_lat (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (gnt_valid),
        .load_val (LW'(MEM_LAT)),
        .dec      (state != ST_IDLE),
        .done     (cnt_done)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= ST_IDLE;
        else state <= next_state;

    // grant moves IDLE to the winner's BUSY state; expiry of the latency returns to IDLE
    always_comb
        next_state = gnt_valid ? ((gnt == GNT_IF) ? ST_BUSY_IF : ST_BUSY_D)
                   : lat_done ? ST_IDLE : state;

    // pipeline freezes while its own request is outstanding
    always_comb begin
        stall_if = if_req & ~if_ack;
        stall_pipe = d_req & ~d_ack;
    end

    // issue: one-cycle strobe and latched address/data of the granted access
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= gnt_valid;
            if (gnt_valid) begin
                mem_we <= (gnt == GNT_D) & d_we;
                mem_addr <= (gnt == GNT_IF) ? if_addr : d_addr;
                if (gnt == GNT_D) mem_wdata <= d_wdata;
            end
        end

    // completion: capture read data and pulse the owner's ack; writes leave d_rdata alone
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            if_ack <= 1'b0;
            d_ack <= 1'b0;
            if_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if_ack <= if_fin;
            d_ack <= d_fin;
            if (if_fin) if_rdata <= mem_rdata;
            if (d_fin && !mem_we) d_rdata <= mem_rdata;
        end

    // a fetch dropped mid-access still completes in memory but is never acknowledged
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) flush_r <= 1'b0;
        else flush_r <= gnt_valid ? 1'b0 : ((state == ST_BUSY_IF) & ~if_req) ? 1'b1 : flush_r;

    // count data grants taken while a fetch waits; any fetch grant clears it
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) starve_cnt <= '0;
        else if (gnt_valid)
            starve_cnt <= (gnt == GNT_IF) ? '0 : (if_req & ~starved) ? starve_cnt + 1'b1 : starve_cnt;

`ifdef ARB_PERF_CNT_EN
    // saturating counters of fetch-stall cycles and idle-cycle request conflicts
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            perf_if_stall <= '0;
            perf_conflict <= '0;
        end else begin
            if (stall_if && perf_if_stall != 16'hFFFF) perf_if_stall <= perf_if_stall + 1'b1;
            if ((state == ST_IDLE) && elig_if && elig_d && perf_conflict != 16'hFFFF)
                perf_conflict <= perf_conflict + 1'b1;
        end
`endif
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed stimulus checked against a transaction-level arbiter model
module tb_cpu_mem_arbiter;
    localparam int LAT = 2;
    localparam int SMAX = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic if_req, d_req, d_we, if_ack, d_ack, stall_if, stall_pipe, mem_en, mem_we;
    logic [15:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_if_stall, perf_conflict;
`endif

    int cyc = 0;
    int passed = 0;
    int total = 0;

    cpu_mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .stall_if(stall_if), .stall_pipe(stall_pipe),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
        , .perf_if_stall(perf_if_stall), .perf_conflict(perf_conflict)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input logic [11:0] a);
        return (a == 12'h004) ? 16'h1234 : (a == 12'h100) ? 16'hCAFE : {4'hA, a};
    endfunction

    // memory macro environment: contents defined by init_val until written
    bit wv [4096];
    logic [15:0] wm [4096];
    always @(posedge clk)
        if (mem_en && mem_we) begin
            wv[mem_addr[11:0]] <= 1'b1;
            wm[mem_addr[11:0]] <= mem_wdata;
        end
    assign mem_rdata = wv[mem_addr[11:0]] ? wm[mem_addr[11:0]] : init_val(mem_addr[11:0]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // model: a grant decided in cycle g strobes in g+1, completes in g+1+LAT, acks in g+2+LAT
    int g_port, g_cyc, issue, ackc, starve;
    bit m_flush, g_we, ai, ad, eif, ed;
    logic [15:0] e_addr, e_wdata, e_ifr, e_dr, g_data;
    bit mv [4096];
    logic [15:0] mm [4096];

    function automatic logic [15:0] model_rd(input logic [11:0] a);
        return mv[a] ? mm[a] : init_val(a);
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            g_port = 0; g_cyc = 0; starve = 0; m_flush = 0; g_we = 0;
            e_addr = 0; e_wdata = 0; e_ifr = 0; e_dr = 0; g_data = 0;
        end else begin
            issue = g_cyc + 1;
            ackc = issue + LAT + 1;
            if (g_port == 1 && cyc >= issue && cyc < ackc && !if_req) m_flush = 1;
            ai = (g_port == 1) && (cyc == ackc) && !m_flush;
            ad = (g_port == 2) && (cyc == ackc);
            if (ai) e_ifr = g_data;
            if (ad && !g_we) e_dr = g_data;
            chk("if_ack", {31'b0, if_ack}, {31'b0, ai});
            chk("d_ack", {31'b0, d_ack}, {31'b0, ad});
            chk("if_rdata", {16'b0, if_rdata}, {16'b0, e_ifr});
            chk("d_rdata", {16'b0, d_rdata}, {16'b0, e_dr});
            chk("stall_if", {31'b0, stall_if}, {31'b0, if_req && !ai});
            chk("stall_pipe", {31'b0, stall_pipe}, {31'b0, d_req && !ad});
            chk("mem_en", {31'b0, mem_en}, {31'b0, g_port != 0 && cyc == issue});
            chk("mem_addr", {16'b0, mem_addr}, {16'b0, e_addr});
            if (g_port != 0 && cyc == issue) begin
                chk("mem_we", {31'b0, mem_we}, {31'b0, g_we});
                if (g_we) chk("mem_wdata", {16'b0, mem_wdata}, {16'b0, e_wdata});
            end
            if (g_port == 0 || cyc >= ackc) begin
                eif = if_req && !ai;
                ed = d_req && !ad;
                if (ed && !(eif && starve == SMAX)) begin
                    g_port = 2; g_cyc = cyc; m_flush = 0; g_we = d_we; e_addr = d_addr;
                    g_data = model_rd(d_addr[11:0]);
                    if (d_we) begin
                        e_wdata = d_wdata;
                        mv[d_addr[11:0]] = 1'b1;
                        mm[d_addr[11:0]] = d_wdata;
                    end
                    if (if_req && starve < SMAX) starve++;
                end else if (eif) begin
                    g_port = 1; g_cyc = cyc; m_flush = 0; g_we = 0; e_addr = if_addr;
                    g_data = model_rd(if_addr[11:0]);
                    starve = 0;
                end
            end
        end
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
        #3;
        chk("rst mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst mem_addr", {16'b0, mem_addr}, 32'd0);
        chk("rst if_rdata", {16'b0, if_rdata}, 32'd0);
        adv(2); reset_n = 1;
        adv(2);
        // isolated fetch
        adv(1); if_req = 1; if_addr = 16'h0004;
        #1 chk("fetch c0 stall_if", {31'b0, stall_if}, 32'd1);
        adv(1); #1 chk("fetch c1 mem_en", {31'b0, mem_en}, 32'd1);
        chk("fetch c1 mem_addr", {16'b0, mem_addr}, 32'h0004);
        adv(3); #1 chk("fetch c4 if_ack", {31'b0, if_ack}, 32'd1);
        chk("fetch c4 if_rdata", {16'b0, if_rdata}, 32'h1234);
        chk("fetch c4 stall_if", {31'b0, stall_if}, 32'd0);
        adv(1); if_req = 0;
        #1 chk("fetch c5 if_ack", {31'b0, if_ack}, 32'd0);
        adv(2);
        // conflict: data wins, fetch follows from the ack cycle
        adv(1); if_req = 1; if_addr = 16'h0008; d_req = 1; d_we = 0; d_addr = 16'h0100;
        adv(1); #1 chk("conf c1 mem_addr", {16'b0, mem_addr}, 32'h0100);
        adv(3); #1 chk("conf c4 d_ack", {31'b0, d_ack}, 32'd1);
        chk("conf c4 d_rdata", {16'b0, d_rdata}, 32'hCAFE);
        adv(1); d_req = 0;
        #1 chk("conf c5 mem_en", {31'b0, mem_en}, 32'd1);
        chk("conf c5 mem_addr", {16'b0, mem_addr}, 32'h0008);
        adv(3); #1 chk("conf c8 if_ack", {31'b0, if_ack}, 32'd1);
        chk("conf c8 if_rdata", {16'b0, if_rdata}, 32'hA008);
        adv(1); if_req = 0;
        adv(2);
        // store, then read it back
        adv(1); d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'hBEEF;
        adv(1); #1 chk("st c1 mem_we", {31'b0, mem_we}, 32'd1);
        chk("st c1 mem_addr", {16'b0, mem_addr}, 32'h0200);
        chk("st c1 mem_wdata", {16'b0, mem_wdata}, 32'hBEEF);
        adv(3); #1 chk("st c4 d_ack", {31'b0, d_ack}, 32'd1);
        chk("st c4 d_rdata", {16'b0, d_rdata}, 32'hCAFE);
        adv(1); d_req = 0; d_we = 0;
        adv(1);
        adv(1); d_req = 1; d_addr = 16'h0200;
        adv(4); #1 chk("ld c4 d_rdata", {16'b0, d_rdata}, 32'hBEEF);
        adv(1); d_req = 0;
        adv(1);
        // starvation: a waiting fetch skipped once forces the next conflict to IF
        adv(1); if_req = 1; if_addr = 16'h0010; d_req = 1; d_addr = 16'h0104;
        adv(1); if_req = 0;
        #1 chk("stv c1 mem_addr", {16'b0, mem_addr}, 32'h0104);
        adv(3); #1 chk("stv c4 d_ack", {31'b0, d_ack}, 32'd1);
        adv(1); d_req = 0;
        adv(1); if_req = 1; if_addr = 16'h0020; d_req = 1; d_addr = 16'h0108;
        adv(1); #1 chk("stv c7 mem_addr", {16'b0, mem_addr}, 32'h0020);
        adv(3); #1 chk("stv c10 if_rdata", {16'b0, if_rdata}, 32'hA020);
        adv(1); if_req = 0;
        #1 chk("stv c11 mem_addr", {16'b0, mem_addr}, 32'h0108);
        adv(3); #1 chk("stv c14 d_rdata", {16'b0, d_rdata}, 32'hA108);
        adv(1); d_req = 0;
        adv(2);
        // flush: fetch dropped mid-access gets no ack, pending load follows
        adv(1); if_req = 1; if_addr = 16'h0030;
        adv(1); #1 chk("fl c1 mem_addr", {16'b0, mem_addr}, 32'h0030);
        adv(1); if_req = 0; d_req = 1; d_addr = 16'h0100;
        adv(2); #1 chk("fl c4 if_ack", {31'b0, if_ack}, 32'd0);
        chk("fl c4 if_rdata", {16'b0, if_rdata}, 32'hA020);
        adv(1); #1 chk("fl c5 mem_en", {31'b0, mem_en}, 32'd1);
        chk("fl c5 mem_addr", {16'b0, mem_addr}, 32'h0100);
        adv(3); #1 chk("fl c8 d_ack", {31'b0, d_ack}, 32'd1);
        adv(1); d_req = 0;
        adv(2);
        // asynchronous reset in the middle of a data access
        adv(1); d_req = 1; d_addr = 16'h0104;
        adv(2); #2 reset_n = 0;
        #1 chk("rst2 mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst2 mem_addr", {16'b0, mem_addr}, 32'd0);
        chk("rst2 d_rdata", {16'b0, d_rdata}, 32'd0);
        chk("rst2 if_rdata", {16'b0, if_rdata}, 32'd0);
        adv(2); reset_n = 1;
        adv(1); #1 chk("rst2 c5 mem_en", {31'b0, mem_en}, 32'd1);
        chk("rst2 c5 mem_addr", {16'b0, mem_addr}, 32'h0104);
        adv(3); #1 chk("rst2 c8 d_ack", {31'b0, d_ack}, 32'd1);
        chk("rst2 c8 d_rdata", {16'b0, d_rdata}, 32'hA104);
        adv(1); d_req = 0;
        adv(3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
